// File: rtl/ram_arbiter_pkg.sv
// Shared defines for the multi-channel RAM arbiter: default base address,
// tag record carried through the response pipeline, and byte-mask expansion.
package ram_arbiter_pkg;

   localparam logic [63:0] DEF_BASE = 64'h8000_0000;
   localparam int          MAX_CH   = 8;
   localparam int          CH_W     = 3;

   typedef struct packed {
      logic            valid;
      logic [CH_W-1:0] id;
      logic            wen;
      logic            err;
   } tag_t;

   // Each byte enable becomes 8 mask bits; narrower data paths use the low bits.
   function automatic logic [63:0] expand_mask(input logic [7:0] be);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{be[i]}};
      return m;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin one-hot grant: the search begins at ptr and wraps once around.
module rr_arb #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int            idx;
   logic [PW-1:0] sel;
   logic          found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (!found && valid[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// N-channel arbiter onto a single-port RAM with fixed read latency; each
// transfer carries a tag down a LATENCY-deep pipeline to produce its response.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter  int          NUM_CH    = 2,
   parameter  int          DATA_W    = 64,
   parameter  int          LATENCY   = 1,
   parameter  logic [63:0] BASE      = DEF_BASE,
   parameter  int          MEM_WORDS = 1 << 20,
   localparam int          BE_W      = DATA_W / 8,
   localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1,
   localparam int          PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH*64-1:0]     req_addr,
   input  logic [NUM_CH-1:0]        req_wen,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   input  logic [NUM_CH*BE_W-1:0]   req_be,
   output logic [NUM_CH-1:0]        resp_valid,
   output logic [DATA_W-1:0]        resp_rdata,
   output logic                     resp_err,
   output logic                     ram_en,
   output logic [IDX_W-1:0]         ram_idx,
   output logic                     ram_wen,
   output logic [DATA_W-1:0]        ram_wdata,
   output logic [DATA_W-1:0]        ram_wmask,
   input  logic [DATA_W-1:0]        ram_rdata
);

   localparam int SHIFT = $clog2(BE_W);

   logic [PW-1:0]     ptr;
   logic [NUM_CH-1:0] grant;
   logic              xfer;
   logic              access;
   logic [PW-1:0]     gid;
   logic [63:0]       sel_addr;
   logic              sel_wen;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;
   logic [63:0]       off;
   logic [63:0]       word;
   logic              sel_err;
   logic [63:0]       mask64;
   tag_t              tag_pipe [LATENCY];
   tag_t              tag_out;

   rr_arb #(.N(NUM_CH)) u_rr (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   // Grant only depends on req_valid, so req_ready is already a transfer strobe.
   assign req_ready = rst ? '0 : grant;
   assign xfer      = |req_ready;

   always_comb begin
      gid       = '0;
      sel_addr  = '0;
      sel_wen   = 1'b0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) begin
            gid       = PW'(i);
            sel_addr  = req_addr[i*64 +: 64];
            sel_wen   = req_wen[i];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_be    = req_be[i*BE_W +: BE_W];
         end
      end
   end

   assign off     = sel_addr - BASE;
   assign word    = off >> SHIFT;
   assign sel_err = (sel_addr < BASE) || (word >= 64'(MEM_WORDS));
   assign mask64  = expand_mask(8'(sel_be));
   assign access  = xfer && !sel_err;

   // Out-of-range transfers are granted but never reach the RAM.
   assign ram_en    = access;
   assign ram_wen   = access && sel_wen;
   assign ram_idx   = access ? word[IDX_W-1:0] : '0;
   assign ram_wdata = access ? sel_wdata : '0;
   assign ram_wmask = access ? mask64[DATA_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (gid == PW'(NUM_CH - 1)) ? '0 : gid + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
      end else begin
         tag_pipe[0] <= '{valid: xfer, id: CH_W'(gid), wen: sel_wen, err: sel_err};
         for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
      end
   end

   assign tag_out = tag_pipe[LATENCY-1];

   // Masked by rst so in-flight tags stay silent in the cycle reset is applied.
   always_comb begin
      resp_valid = '0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      if (tag_out.valid && !rst) begin
         for (int i = 0; i < NUM_CH; i++) resp_valid[i] = (tag_out.id == CH_W'(i));
         resp_err = tag_out.err;
         if (!tag_out.err && !tag_out.wen) resp_rdata = ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a 2-channel latency-1 instance run against a queue-based
// reference model, plus latency-3 and 4-channel instances for directed corners.
module tb_ram_arbiter;

   localparam int          DW   = 64;
   localparam int          MW   = 256;
   localparam int          LA   = 1;
   localparam logic [63:0] BASE = 64'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [1:0]  rdy;
      logic [1:0]  rv;
      logic        en;
      logic        wen;
      logic        err;
      logic [7:0]  idx;
      logic [63:0] wm;
      logic [63:0] rd;
   } obs_t;

   typedef struct {
      int          due;
      int          ch;
      logic        err;
      logic [63:0] data;
   } exp_t;

   // ---------------- instance A: 2 channels, latency 1 ----------------
   logic        rst_a;
   logic [1:0]  v_a, rdy_a, wen_a, rv_a;
   logic [127:0] addr_a, wd_a;
   logic [15:0] be_a;
   logic [63:0] rd_a, rwd_a, rwm_a, rrd_a;
   logic        err_a, en_a, rwen_a;
   logic [7:0]  idx_a;
   logic [63:0] mem_a [MW];

   ram_arbiter #(.NUM_CH(2), .DATA_W(DW), .LATENCY(LA), .BASE(BASE), .MEM_WORDS(MW)) u_a (
      .clk(clk), .rst(rst_a), .req_valid(v_a), .req_ready(rdy_a), .req_addr(addr_a),
      .req_wen(wen_a), .req_wdata(wd_a), .req_be(be_a), .resp_valid(rv_a),
      .resp_rdata(rd_a), .resp_err(err_a), .ram_en(en_a), .ram_idx(idx_a),
      .ram_wen(rwen_a), .ram_wdata(rwd_a), .ram_wmask(rwm_a), .ram_rdata(rrd_a)
   );

   function automatic logic [63:0] init_word(input int i);
      return (i == 1) ? 64'hDEAD : (64'hC0DE_0000_0000_0000 | 64'(i * 7 + 3));
   endfunction

   // RAM stub with one-cycle read latency
   always @(posedge clk) begin
      if (rst_a) begin
         for (int i = 0; i < MW; i++) mem_a[i] <= init_word(i);
      end else if (en_a) begin
         if (rwen_a) mem_a[idx_a] <= (mem_a[idx_a] & ~rwm_a) | (rwd_a & rwm_a);
         else        rrd_a <= mem_a[idx_a];
      end
   end

   // ---------------- instance B: 2 channels, latency 3 ----------------
   logic        rst_b;
   logic [1:0]  v_b, rdy_b, wen_b, rv_b;
   logic [127:0] addr_b, wd_b;
   logic [15:0] be_b;
   logic [63:0] rd_b, rwd_b, rwm_b;
   logic [63:0] rrd_b = 64'h5555;
   logic        err_b, en_b, rwen_b;
   logic [7:0]  idx_b;

   ram_arbiter #(.NUM_CH(2), .DATA_W(DW), .LATENCY(3), .BASE(BASE), .MEM_WORDS(MW)) u_b (
      .clk(clk), .rst(rst_b), .req_valid(v_b), .req_ready(rdy_b), .req_addr(addr_b),
      .req_wen(wen_b), .req_wdata(wd_b), .req_be(be_b), .resp_valid(rv_b),
      .resp_rdata(rd_b), .resp_err(err_b), .ram_en(en_b), .ram_idx(idx_b),
      .ram_wen(rwen_b), .ram_wdata(rwd_b), .ram_wmask(rwm_b), .ram_rdata(rrd_b)
   );

   // ---------------- instance C: 4 channels, latency 1 ----------------
   logic        rst_c;
   logic [3:0]  v_c, rdy_c, wen_c, rv_c;
   logic [255:0] addr_c, wd_c;
   logic [31:0] be_c;
   logic [63:0] rd_c, rwd_c, rwm_c;
   logic [63:0] rrd_c = 64'h0;
   logic        err_c, en_c, rwen_c;
   logic [7:0]  idx_c;

   ram_arbiter #(.NUM_CH(4), .DATA_W(DW), .LATENCY(1), .BASE(BASE), .MEM_WORDS(MW)) u_c (
      .clk(clk), .rst(rst_c), .req_valid(v_c), .req_ready(rdy_c), .req_addr(addr_c),
      .req_wen(wen_c), .req_wdata(wd_c), .req_be(be_c), .resp_valid(rv_c),
      .resp_rdata(rd_c), .resp_err(err_c), .ram_en(en_c), .ram_idx(idx_c),
      .ram_wen(rwen_c), .ram_wdata(rwd_c), .ram_wmask(rwm_c), .ram_rdata(rrd_c)
   );

   // ---------------- reference model for A ----------------
   int          m_ptr;
   logic [63:0] m_mem [MW];
   exp_t        q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step_a(input logic [1:0] v, input logic [1:0] w,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [7:0] b0, input logic [7:0] b1,
                         output obs_t o);
      int          g, ix;
      logic [63:0] a, d, m, dat;
      logic [7:0]  b;
      logic        e;
      v_a = v; wen_a = w; addr_a = {a1, a0}; wd_a = {d1, d0}; be_a = {b1, b0};
      @(negedge clk);
      o = '{rdy_a, rv_a, en_a, rwen_a, err_a, idx_a, rwm_a, rd_a};
      g = -1;
      for (int k = 0; k < 2; k++) if (g < 0 && v[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      chk("a_ready", 64'(rdy_a), (g < 0) ? 64'd0 : (64'd1 << g));
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("a_resp_valid", 64'(rv_a), 64'd1 << q[0].ch);
         chk("a_resp_err", 64'(err_a), 64'(q[0].err));
         chk("a_resp_rdata", rd_a, q[0].data);
         void'(q.pop_front());
      end else begin
         chk("a_resp_idle", 64'(rv_a), 64'd0);
      end
      if (g >= 0) begin
         a = (g == 1) ? a1 : a0;
         d = (g == 1) ? d1 : d0;
         b = (g == 1) ? b1 : b0;
         e = (a < BASE) || (((a - BASE) >> 3) >= 64'(MW));
         ix = e ? 0 : int'((a - BASE) >> 3);
         for (int j = 0; j < 8; j++) m[j*8 +: 8] = {8{b[j]}};
         chk("a_ram_en", 64'(en_a), 64'(!e));
         chk("a_ram_wen", 64'(rwen_a), 64'(!e && w[g]));
         if (!e) chk("a_ram_idx", 64'(idx_a), 64'(ix));
         if (!e && w[g]) begin
            chk("a_ram_wmask", rwm_a, m);
            chk("a_ram_wdata", rwd_a, d);
         end
         dat = (!e && !w[g]) ? m_mem[ix] : 64'd0;
         if (!e && w[g]) m_mem[ix] = (m_mem[ix] & ~m) | (d & m);
         q.push_back('{cyc + LA, g, e, dat});
         m_ptr = (g + 1) % 2;
      end else begin
         chk("a_idle_ram", {rwm_a[61:0], en_a, rwen_a} | 64'(idx_a), 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   function automatic logic [63:0] rnd_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return BASE - 64'($urandom_range(1, 64));
      if (r == 1) return BASE + 64'(MW * 8) + 64'($urandom_range(0, 64));
      return BASE + 64'($urandom_range(0, MW * 8 - 1));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      obs_t o;
      logic [3:0] exp_c [5];
      exp_c = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      v_a = 2'b11; wen_a = '0; addr_a = {BASE, BASE}; wd_a = '0; be_a = '1;
      v_b = '0;    wen_b = '0; addr_b = {BASE, BASE}; wd_b = '0; be_b = '1;
      v_c = '0;    wen_c = '0; addr_c = {4{BASE}};    wd_c = '0; be_c = '1;
      for (int i = 0; i < MW; i++) m_mem[i] = init_word(i);
      m_ptr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(rdy_a), 64'd0);
      chk("rst_resp_valid", 64'(rv_a), 64'd0);
      chk("rst_ram_en", 64'(en_a), 64'd0);
      chk("rst_resp_err_rdata", rd_a | 64'(err_a), 64'd0);
      @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // both channels requesting continuously: grants alternate from ch0
      for (int k = 0; k < 6; k++) begin
         step_a(2'b11, 2'b00, BASE + 64'(k * 8), BASE + 64'(k * 8 + 64), '0, '0, 8'hFF, 8'hFF, o);
         chk("alt_grant", 64'(o.rdy), (k % 2 == 0) ? 64'd1 : 64'd2);
      end

      // ch0 read of word 1
      step_a(2'b01, 2'b00, 64'h8000_0008, BASE, '0, '0, 8'hFF, 8'hFF, o);
      chk("rd_idx", 64'(o.idx), 64'd1);
      chk("rd_en", 64'(o.en), 64'd1);
      // ch1 partial write, upper half only
      step_a(2'b10, 2'b10, BASE, 64'h8000_0004, '0, 64'h1234_5678_0000_0000, 8'h00, 8'hF0, o);
      chk("rd_resp_valid", 64'(o.rv), 64'd1);
      chk("rd_resp_rdata", o.rd, 64'hDEAD);
      chk("wr_wmask", o.wm, 64'hFFFF_FFFF_0000_0000);
      chk("wr_wen", 64'(o.wen), 64'd1);
      // read below BASE
      step_a(2'b01, 2'b00, 64'h7FFF_FFF8, BASE, '0, '0, 8'hFF, 8'hFF, o);
      chk("wr_resp_valid", 64'(o.rv), 64'd2);
      chk("wr_resp_rdata", o.rd, 64'd0);
      chk("err_ram_en", 64'(o.en), 64'd0);
      // read of last word, then first word past the end
      step_a(2'b01, 2'b00, BASE + 64'((MW - 1) * 8), BASE, '0, '0, 8'hFF, 8'hFF, o);
      chk("err_resp_err", 64'(o.err), 64'd1);
      chk("err_resp_rdata", o.rd, 64'd0);
      chk("last_word_en", 64'(o.en), 64'd1);
      step_a(2'b10, 2'b00, BASE, BASE + 64'(MW * 8), '0, '0, 8'hFF, 8'hFF, o);
      chk("past_end_en", 64'(o.en), 64'd0);
      // read back word 0 after the partial write
      step_a(2'b01, 2'b00, BASE, BASE, '0, '0, 8'hFF, 8'hFF, o);
      step_a(2'b00, 2'b00, BASE, BASE, '0, '0, 8'hFF, 8'hFF, o);
      chk("rmw_readback", o.rd, 64'h1234_5678_0000_0000 | (init_word(0) & 64'hFFFF_FFFF));

      for (int n = 0; n < 400; n++)
         step_a(2'($urandom), 2'($urandom), rnd_addr(), rnd_addr(),
                {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 8'($urandom), o);
      step_a(2'b00, 2'b00, BASE, BASE, '0, '0, 8'hFF, 8'hFF, o);
      chk("a_queue_drained", 64'(q.size()), 64'd0);

      // B: latency-3 timing on ch1, then reset with three tags in flight
      v_b = 2'b10;
      @(negedge clk);
      chk("b_lat_grant", 64'(rdy_b), 64'd2);
      @(posedge clk); #1;
      v_b = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("b_lat_valid", 64'(rv_b), (k == 3) ? 64'd2 : 64'd0);
         if (k == 3) chk("b_lat_rdata", rd_b, 64'h5555);
         @(posedge clk); #1;
      end
      v_b = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b_b2b_grant", 64'(rdy_b), (k == 1) ? 64'd2 : 64'd1);
         @(posedge clk); #1;
      end
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_ready", 64'(rdy_b), 64'd0);
      chk("b_rst_valid", 64'(rv_b), 64'd0);
      @(posedge clk); #1;
      rst_b = 1'b0;
      @(negedge clk);
      chk("b_post_rst_grant", 64'(rdy_b), 64'd1);
      @(posedge clk); #1;
      v_b = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("b_post_rst_valid", 64'(rv_b), (k == 3) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
      end

      // C: move ptr to 2 via a ch1 grant, then ch1+ch3 and a full rotation
      v_c = 4'b0010;
      @(negedge clk);
      chk("c_grant_ch1", 64'(rdy_c), 64'd2);
      @(posedge clk); #1;
      v_c = 4'b1010;
      @(negedge clk);
      chk("c_first_ch3", 64'(rdy_c), 64'd8);
      @(posedge clk); #1;
      @(negedge clk);
      chk("c_then_ch1", 64'(rdy_c), 64'd2);
      @(posedge clk); #1;
      v_c = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("c_rotate", 64'(rdy_c), 64'(exp_c[k]));
         @(posedge clk); #1;
      end
      v_c = 4'b0000;
      @(negedge clk);
      chk("c_idle", 64'(rdy_c) | 64'(en_c), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requester channels, legal range 1..8.
REQ-002 SHALL have parameter DATA_W, default 64: data width; legal values 32 and 64.
REQ-003 SHALL have parameter LATENCY, default 1: cycles from ram_en to ram_rdata valid; legal range 1..4.
REQ-004 SHALL have parameter BASE, default 64'h8000_0000: address of RAM word 0.
REQ-005 SHALL have parameter MEM_WORDS, default 2^20: RAM depth in words.
REQ-006 SHALL have one clock and a synchronous, active-high reset: port clk (input, 1, clock) and port rst (input, 1, synchronous active-high reset).
REQ-007 SHALL have port req_valid, input, NUM_CH bits: per-channel request.
REQ-008 SHALL have port req_ready, output, NUM_CH bits: per-channel grant.
REQ-009 SHALL have port req_addr, input, NUM_CH*64 bits: byte address per channel.
REQ-010 SHALL have port req_wen, input, NUM_CH bits: write when 1, read when 0.
REQ-011 SHALL have port req_wdata, input, NUM_CH*DATA_W bits: write data, already lane-aligned.
REQ-012 SHALL have port req_be, input, NUM_CH*(DATA_W/8) bits: byte enables.
REQ-013 SHALL have port resp_valid, output, NUM_CH bits: one-cycle completion pulse.
REQ-014 SHALL have port resp_rdata, output, DATA_W bits: read data shared by all channels.
REQ-015 SHALL have port resp_err, output, 1 bit: out-of-range access flag.
REQ-016 SHALL have ports ram_en, ram_idx, ram_wen, ram_wdata and ram_wmask, all outputs: RAM request, with ram_wmask DATA_W bits wide as a bit mask.
REQ-017 SHALL have port ram_rdata, input, DATA_W bits: RAM read data.

Function
REQ-018 SHALL grant at most one channel per cycle: req_ready[i]=1 only for the winner, combinational from req_valid.
REQ-019 A transfer SHALL occur on a cycle with req_valid[i]&req_ready[i] = 1.
REQ-020 Arbitration SHALL be round-robin: the search starts at pointer ptr; after a grant to channel g, ptr SHALL become (g+1) mod NUM_CH; ptr SHALL hold when there is no grant.
REQ-021 On a transfer, ram_idx SHALL equal (addr-BASE)>>log2(DATA_W/8).
REQ-022 On a transfer, ram_wmask SHALL equal the byte enables expanded to 8 bits each.
REQ-023 On a transfer, ram_en SHALL be asserted for a read and ram_wen for a write.
REQ-024 A request with addr<BASE or index>=MEM_WORDS SHALL be granted with ram_en=ram_wen=0, and SHALL be flagged as an error.
REQ-025 Each transfer SHALL enter a LATENCY-deep tag pipeline holding {valid, channel id, wen, err}.
REQ-026 Exactly LATENCY cycles after a transfer, resp_valid[id] SHALL pulse for one cycle.
REQ-027 With the pulse, resp_rdata SHALL be ram_rdata for a non-error read and 0 for a write or error.
REQ-028 With the pulse, resp_err SHALL equal the captured err.
REQ-029 Throughput SHALL be one transfer per cycle; the response path SHALL have no backpressure.
REQ-030 A channel that deasserts req_valid before it is granted SHALL lose nothing and SHALL NOT change ptr.
REQ-031 When all channels request every cycle, grants SHALL rotate 0,1,..,NUM_CH-1,0 (wrap).
REQ-032 When NUM_CH=1, the grant SHALL be req_valid[0] and ptr SHALL be constant 0.
REQ-033 When idle, all ram_* outputs SHALL be 0.

Reset
REQ-034 While rst=1: ptr=0, tag pipeline cleared, and req_ready, resp_valid, resp_err, resp_rdata, ram_en, ram_wen all 0.
REQ-035 Reset asserted with transfers in flight SHALL discard them; no resp_valid SHALL follow for them after rst deasserts.
REQ-036 The first grant after reset SHALL go to the lowest-numbered requesting channel.

Structure
REQ-037 BASE default, the mask-expansion function and the tag record type SHALL live in the shared package with the other core defines.
REQ-038 The round-robin grant logic SHALL be the sub-module rr_arb (parameter N; ports valid, ptr, grant one-hot); the tag pipeline and address decode SHALL stay in ram_arbiter.

Verification
REQ-039 Bench SHALL cover: NUM_CH=2, LATENCY=1, ch0 read 0x8000_0008 with RAM word1=0xDEAD -> ram_idx=1 and ram_en during the transfer cycle, resp_valid=2'b01 and resp_rdata=0xDEAD next cycle.
REQ-040 Bench SHALL cover: both channels requesting continuously for 6 cycles -> grants 0,1,0,1,0,1 and each response LATENCY cycles after its grant.
REQ-041 Bench SHALL cover: ch1 write addr 0x8000_0004, be=8'hF0, wdata=0x1234_5678_0000_0000 -> ram_wmask=0xFFFF_FFFF_0000_0000, ram_wen=1, resp_rdata=0.
REQ-042 Bench SHALL cover: read at 0x7FFF_FFF8 -> ram_en=0, resp_valid after LATENCY cycles with resp_err=1 and resp_rdata=0.
REQ-043 Bench SHALL cover: LATENCY=3 with three back-to-back grants, then rst asserted for 1 cycle -> no resp_valid after reset and ptr=0.
REQ-044 Bench SHALL cover: NUM_CH=4 with requests on ch1 and ch3, ptr=2 -> ch3 granted first, then ch1.
